// File: rtl/gray_counter.sv
// ----------------------------------------------------------------------------
// gray_counter
//   Parametrised up/down counter. It has registered binary and Gray outputs.
//   The Gray value has its own register and is not decoded from bin_out, so
//   gray_out is glitch-free and safe to sample from another clock domain.
//   A load can be given in binary or in Gray code. A Gray load is decoded
//   to binary internally.
//
// Parameters
//   DATA_WIDTH   counter width in bits (>= 2)
//   RESET_VALUE  binary count applied while rst_n is low
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   en            count enable, one step per clock
//   up_dn         1 = increment, 0 = decrement
//   load          load load_value at the next edge (overrides en)
//   load_is_gray  1 = load_value is Gray-coded, 0 = binary
//   load_value    value to load
//   bin_out       registered binary count
//   gray_out      registered Gray count, always gray(bin_out)
//   gray_next     combinational gray() of the count after the next edge
//   wrap          registered one-cycle pulse when the count wraps around
//
// Configuration
//   GRAY_CNT_SATURATE_EN  when defined, counting saturates at 2^W-1 (up) and
//                         at 0 (down). wrap then becomes a level "sat" flag:
//                         it is high while bin_out is at the limit for the
//                         current direction and en is set.
// ----------------------------------------------------------------------------
module gray_counter #(
   parameter int unsigned           DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic                  load_is_gray,
   input  logic [DATA_WIDTH-1:0] load_value,
   output logic [DATA_WIDTH-1:0] bin_out,
   output logic [DATA_WIDTH-1:0] gray_out,
   output logic [DATA_WIDTH-1:0] gray_next,
   output logic                  wrap
);

   localparam logic [DATA_WIDTH-1:0] MAX_VAL = '1;
   localparam logic [DATA_WIDTH-1:0] MIN_VAL = '0;
   localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [DATA_WIDTH-1:0] bin2gray(input logic [DATA_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it. This is the
   // unrolled form of b[i] = b[i+1] ^ g[i].
   function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
      logic [DATA_WIDTH-1:0] b;
      b = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   localparam logic [DATA_WIDTH-1:0] RESET_GRAY = RESET_VALUE ^ (RESET_VALUE >> 1);

   logic [DATA_WIDTH-1:0] bin_q;
   logic [DATA_WIDTH-1:0] gray_q;
   logic                  wrap_q;

   logic [DATA_WIDTH-1:0] bin_nxt;
   logic [DATA_WIDTH-1:0] bin_step;
   logic                  wrap_nxt;
   logic                  at_limit;

   // Next-state selection. Priority is load, then en, then hold.
   always_comb begin
      bin_step = up_dn ? (bin_q + ONE) : (bin_q - ONE);
      at_limit = up_dn ? (bin_q == MAX_VAL) : (bin_q == MIN_VAL);
      bin_nxt  = bin_q;
      wrap_nxt = 1'b0;
      if (load) begin
         bin_nxt = load_is_gray ? gray2bin(load_value) : load_value;
      end else if (en) begin
`ifdef GRAY_CNT_SATURATE_EN
         bin_nxt  = at_limit ? bin_q : bin_step;
         // sat level: the count that is being registered sits at the limit
         // for the direction currently selected.
         wrap_nxt = up_dn ? (bin_nxt == MAX_VAL) : (bin_nxt == MIN_VAL);
`else
         bin_nxt  = bin_step;
         // The pulse lines up with the cycle in which the wrapped value is
         // first visible on bin_out.
         wrap_nxt = at_limit;
`endif
      end
   end

   // Both count registers load on the same edge, so bin_out and gray_out
   // never disagree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= RESET_VALUE;
         gray_q <= RESET_GRAY;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_nxt;
         gray_q <= bin2gray(bin_nxt);
         wrap_q <= wrap_nxt;
      end
   end

   // While reset is held, the next value is the reset value that is already
   // being shown.
   assign gray_next = rst_n ? bin2gray(bin_nxt) : gray_q;

   assign bin_out  = bin_q;
   assign gray_out = gray_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// ----------------------------------------------------------------------------
// tb_gray_counter
//   Self-checking bench for gray_counter with DATA_WIDTH=4 and RESET_VALUE=0.
//   Directed scenarios are followed by randomized traffic. All of it is
//   checked against an integer reference model of the counter.
// ----------------------------------------------------------------------------
module tb_gray_counter;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         up_dn;
   logic         load;
   logic         load_is_gray;
   logic [W-1:0] load_value;
   logic [W-1:0] bin_out;
   logic [W-1:0] gray_out;
   logic [W-1:0] gray_next;
   logic         wrap;

   gray_counter #(
      .DATA_WIDTH  (W),
      .RESET_VALUE (4'd0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .up_dn        (up_dn),
      .load         (load),
      .load_is_gray (load_is_gray),
      .load_value   (load_value),
      .bin_out      (bin_out),
      .gray_out     (gray_out),
      .gray_next    (gray_next),
      .wrap         (wrap)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model (plain integer arithmetic) -------------
   int m_bin  = 0;
   int m_wrap = 0;
   int p_bin;
   int p_wrap;

   function automatic int g_of(input int b);
      return b ^ (b >> 1);
   endfunction

   // Decode by search: the binary value whose Gray code matches.
   function automatic int g_dec(input int g);
      for (int b = 0; b <= MAXV; b++) if (g_of(b) == g) return b;
      return -1;
   endfunction

   task automatic model_next(input bit ld, input bit lg, input int lv, input bit e, input bit u);
      if (ld) begin
         p_bin  = lg ? g_dec(lv) : lv;
         p_wrap = 0;
      end else if (e) begin
`ifdef GRAY_CNT_SATURATE_EN
         if (u) p_bin = (m_bin == MAXV) ? MAXV : m_bin + 1;
         else   p_bin = (m_bin == 0) ? 0 : m_bin - 1;
         p_wrap = u ? int'(p_bin == MAXV) : int'(p_bin == 0);
`else
         p_bin  = (m_bin + (u ? 1 : MAXV)) % (MAXV + 1);
         p_wrap = u ? int'(m_bin == MAXV) : int'(m_bin == 0);
`endif
      end else begin
         p_bin  = m_bin;
         p_wrap = 0;
      end
   endtask

   // Drive inputs, let them settle, then check the combinational look-ahead.
   task automatic set_in(input bit ld, input bit lg, input int lv, input bit e, input bit u);
      load         = ld;
      load_is_gray = lg;
      load_value   = lv[W-1:0];
      en           = e;
      up_dn        = u;
      #1;
      model_next(ld, lg, lv, e, u);
      check("gray_next", gray_next, g_of(p_bin));
   endtask

   // Clock once. Outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      m_bin  = p_bin;
      m_wrap = p_wrap;
      check("bin_out", bin_out, m_bin);
      check("gray_out", gray_out, g_of(m_bin));
      check("wrap", wrap, m_wrap);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] gseq [0:17];
      logic [W-1:0] prev_g;

      gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};

      // ---- reset state; inputs busy to show reset dominates ----
      rst_n = 1'b0;
      load = 1'b1; load_is_gray = 1'b0; load_value = 4'd5; en = 1'b1; up_dn = 1'b1;
      #3;
      check("rst_bin", bin_out, 0);
      check("rst_gray", gray_out, 0);
      check("rst_wrap", wrap, 0);
      check("rst_gray_next", gray_next, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_bin = 0; m_wrap = 0;
      @(posedge clk);
      #1;
      // Reset was released at a negedge with load high. That posedge loaded 5.
      m_bin = 5;
      check("post_rst_load", bin_out, 5);

`ifndef GRAY_CNT_SATURATE_EN
      // ---- full up-count sequence through wrap ----
      set_in(1, 0, 0, 0, 1);
      tick();
      prev_g = gray_out;
      check("seq_0", gray_out, gseq[0]);
      for (int k = 1; k <= 17; k++) begin
         set_in(0, 0, 0, 1, 1);
         tick();
         check("seq_gray", gray_out, gseq[k]);
         check("seq_onebit", $countones(prev_g ^ gray_out), 1);
         check("seq_wrap", wrap, (k == 16) ? 1 : 0);
         prev_g = gray_out;
      end

      // ---- down-count through zero ----
      set_in(1, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 1, 0);
      tick();
      check("dn_bin", bin_out, 15);
      check("dn_gray", gray_out, 4'b1000);
      check("dn_wrap", wrap, 1);
      set_in(0, 0, 0, 1, 0);
      tick();
      check("dn2_bin", bin_out, 14);
      check("dn2_gray", gray_out, 4'b1001);
      check("dn2_wrap", wrap, 0);
`else
      // ---- saturation ----
      set_in(1, 0, 13, 0, 1);
      tick();
      for (int k = 0; k < 5; k++) begin
         set_in(0, 0, 0, 1, 1);
         tick();
         check("sat_bin", bin_out, (k == 0) ? 14 : 15);
         check("sat_flag", wrap, (k == 0) ? 0 : 1);
      end
      set_in(0, 0, 0, 1, 0);
      tick();
      check("sat_dn_bin", bin_out, 14);
      check("sat_dn_flag", wrap, 0);
`endif

      // ---- Gray and binary loads ----
      set_in(1, 1, 4'b1101, 0, 1);
      tick();
      check("gload_bin", bin_out, 9);
      check("gload_gray", gray_out, 4'b1101);
      check("gload_wrap", wrap, 0);
      set_in(1, 0, 0, 1, 1);
      tick();
      set_in(1, 0, 9, 0, 0);
      tick();
      check("bload_bin", bin_out, 9);
      check("bload_gray", gray_out, 4'b1101);

      // ---- load beats enable ----
      set_in(1, 0, 5, 0, 1);
      tick();
      set_in(1, 0, 2, 1, 1);
      check("prio_gray_next", gray_next, 4'b0011);
      tick();
      check("prio_bin", bin_out, 2);

      // ---- async reset mid-count ----
      set_in(1, 0, 6, 0, 1);
      tick();
      set_in(0, 0, 0, 1, 1);
      tick();
      check("pre_arst_bin", bin_out, 7);
      set_in(0, 0, 0, 1, 1);
      rst_n = 1'b0;
      #1;
      check("arst_bin", bin_out, 0);
      check("arst_gray", gray_out, 0);
      check("arst_wrap", wrap, 0);
      check("arst_gray_next", gray_next, 0);
      #2;
      rst_n = 1'b1;
      m_bin = 0; m_wrap = 0;
      set_in(0, 0, 0, 1, 1);
      tick();
      check("arst_resume", bin_out, 1);

      // ---- randomized traffic against the model ----
      for (int k = 0; k < 400; k++) begin
         bit ld, lg, e, u;
         int lv;
         ld = ($urandom_range(0, 9) == 0);
         lg = $urandom_range(0, 1) != 0;
         lv = $urandom_range(0, MAXV);
         e  = ($urandom_range(0, 3) != 0);
         u  = ($urandom_range(0, 2) != 0);
         set_in(ld, lg, lv, e, u);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
